// File: rtl/va_readout_ctrl.sv
// va_readout_ctrl
//   Buffers analyzer result words in a show-ahead FIFO and serves them to the
//   HPS over a 4-word Avalon-MM slave (DATA / STATUS / CONTROL / DROPCNT).
//   Optional feature macro: VA_READOUT_DROPCNT_EN (16-bit saturating drop
//   counter at addr 3; when undefined addr 3 reads 0 and no counter exists).
// Ports:
//   clk, reset_n          single clock, async active-low reset
//   address/read/write    Avalon slave, 2-bit word address, no waitrequest
//   writedata/readdata    32-bit data, readdata registered (latency 1)
//   in_data/in_valid      analyzer result strobe, no backpressure
//   irq                   registered level interrupt
module va_readout_ctrl #(
  parameter int DEPTH_LOG2 = 4,
  localparam int LVL_W = DEPTH_LOG2 + 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        irq
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  enable_q, enable_d;
  logic                  overflow_q, overflow_d;
  logic                  irq_q, irq_d;
  logic [31:0]           readdata_q, readdata_d;
  logic [31:0]           status, dropcnt_rd;

  logic empty, full, rd_data, pop, push, drop, wr_ctrl, flush, clr_ovf;
  logic unused_wdata;

  assign unused_wdata = ^writedata[31:3];

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_W'(DEPTH));
  assign rd_data = read && (address == 2'd0);
  // An empty FIFO ignores the pop; a concurrent push still lands.
  assign pop     = rd_data && !empty;
  assign wr_ctrl = write && (address == 2'd2);
  assign flush   = wr_ctrl && writedata[1];
  assign clr_ovf = wr_ctrl && writedata[2];
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  // Flush discards the incoming word without counting it as a drop.
  assign push    = in_valid && enable_q && (!full || pop) && !flush;
  assign drop    = in_valid && enable_q && full && !pop && !flush;

`ifdef VA_READOUT_DROPCNT_EN
  logic [15:0] dropcnt_q, dropcnt_d;

  always_comb begin
    dropcnt_d = dropcnt_q;
    if (clr_ovf)                           dropcnt_d = drop ? 16'd1 : 16'd0;
    else if (drop && dropcnt_q != 16'hFFFF) dropcnt_d = dropcnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) dropcnt_q <= '0;
    else          dropcnt_q <= dropcnt_d;

  assign dropcnt_rd = {16'b0, dropcnt_q};
`else
  assign dropcnt_rd = '0;
`endif

  always_comb begin
    status              = '0;
    status[LVL_W-1:0]   = level_q;
    status[16]          = empty;
    status[17]          = full;
    status[18]          = overflow_q;
    status[19]          = enable_q;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    enable_d   = enable_q;
    overflow_d = overflow_q;
    readdata_d = readdata_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end

    if (wr_ctrl) enable_d = writedata[0];
    // Set beats clear when a drop coincides with the clear request.
    if (drop)         overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;

    if (read) begin
      unique case (address)
        2'd0:    readdata_d = empty ? 32'd0 : mem_q[rd_ptr_q];
        2'd1:    readdata_d = status;
        2'd2:    readdata_d = {31'b0, enable_q};
        default: readdata_d = dropcnt_rd;
      endcase
    end

    irq_d = (enable_q && (level_q >= LVL_W'(DEPTH / 2))) || overflow_q;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      enable_q   <= 1'b0;
      overflow_q <= 1'b0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      enable_q   <= enable_d;
      overflow_q <= overflow_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end

  // Storage is not reset; empty-gating on the DATA read hides stale words.
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= in_data;

  assign readdata = readdata_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_va_readout_ctrl.sv
module tb_va_readout_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        read = 1'b0, write = 1'b0, in_valid = 1'b0;
  logic [31:0] writedata = '0, in_data = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [31:0] rv;
  int          n_vec = 0, n_miss = 0;

`ifdef VA_READOUT_DROPCNT_EN
  localparam logic [31:0] DROP2 = 32'd2;
  localparam logic [31:0] DROP0 = 32'd0;
`else
  localparam logic [31:0] DROP2 = 32'd0;
  localparam logic [31:0] DROP0 = 32'd0;
`endif

  va_readout_ctrl #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read),
    .write(write), .writedata(writedata), .readdata(readdata),
    .in_data(in_data), .in_valid(in_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; readdata is sampled on the next one.
  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk); address = a; read = 1'b1;
    @(negedge clk); read = 1'b0; d = readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); address = a; writedata = d; write = 1'b1;
    @(negedge clk); write = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    @(negedge clk); in_data = d; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    rd(2'd1, rv); chk("rst_status", rv, 32'h0001_0000);
    rd(2'd0, rv); chk("rst_data_empty", rv, 32'h0);
    rd(2'd3, rv); chk("rst_dropcnt", rv, 32'h0);

    // enabled, 3 words in order
    wr(2'd2, 32'h1);
    rd(2'd2, rv); chk("ctrl_rd", rv, 32'h1);
    push(32'hA5A5_0001); push(32'hA5A5_0002); push(32'hA5A5_0003);
    rd(2'd1, rv); chk("lvl3_status", rv, 32'h0008_0003);
    rd(2'd0, rv); chk("data_w1", rv, 32'hA5A5_0001);
    @(negedge clk); chk("data_hold", readdata, 32'hA5A5_0001);
    rd(2'd0, rv); chk("data_w2", rv, 32'hA5A5_0002);
    rd(2'd0, rv); chk("data_w3", rv, 32'hA5A5_0003);
    rd(2'd1, rv); chk("lvl0_status", rv, 32'h0009_0000);
    rd(2'd0, rv); chk("data_empty", rv, 32'h0);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, rv); chk("status_wr_ignored", rv, 32'h0009_0000);

    // overflow: 18 pushes into 16 slots
    for (int i = 0; i < 18; i++) push(32'h100 + i);
    rd(2'd1, rv); chk("full_status", rv, 32'h000E_0010);
    rd(2'd3, rv); chk("dropcnt_2", rv, DROP2);
    chk("full_irq", {31'b0, irq}, 32'h1);

    // full FIFO, push coincident with DATA pop
    @(negedge clk); address = 2'd0; read = 1'b1; in_data = 32'hBEEF_0000; in_valid = 1'b1;
    @(negedge clk); read = 1'b0; in_valid = 1'b0;
    chk("full_pop_oldest", readdata, 32'h100);
    rd(2'd1, rv); chk("full_pushpop_lvl", rv, 32'h000E_0010);
    rd(2'd3, rv); chk("full_pushpop_nodrop", rv, DROP2);

    // flush keeps overflow and enable
    wr(2'd2, 32'h3);
    rd(2'd1, rv); chk("flush_status", rv, 32'h000D_0000);
    for (int i = 0; i < 5; i++) push(32'h200 + i);
    rd(2'd1, rv); chk("lvl5_status", rv, 32'h000C_0005);
    @(negedge clk); address = 2'd2; writedata = 32'h3; write = 1'b1;
    in_data = 32'hDEAD_0000; in_valid = 1'b1;
    @(negedge clk); write = 1'b0; in_valid = 1'b0;
    rd(2'd1, rv); chk("flush_push_status", rv, 32'h000D_0000);
    rd(2'd3, rv); chk("flush_no_drop", rv, DROP2);

    // clear overflow
    wr(2'd2, 32'h5);
    rd(2'd1, rv); chk("clr_ovf_status", rv, 32'h0009_0000);
    rd(2'd3, rv); chk("clr_dropcnt", rv, DROP0);
    @(negedge clk); chk("irq_clear", {31'b0, irq}, 32'h0);

    // push+pop on empty: pop ignored, push kept
    @(negedge clk); address = 2'd0; read = 1'b1; in_data = 32'h0000_0055; in_valid = 1'b1;
    @(negedge clk); read = 1'b0; in_valid = 1'b0;
    chk("empty_pushpop_rd", readdata, 32'h0);
    rd(2'd1, rv); chk("empty_pushpop_lvl", rv, 32'h0008_0001);
    rd(2'd0, rv); chk("empty_pushpop_word", rv, 32'h0000_0055);

    // reset mid-burst at level 7
    for (int i = 0; i < 7; i++) push(32'h300 + i);
    rd(2'd1, rv); chk("lvl7_status", rv, 32'h0008_0007);
    @(negedge clk); in_data = 32'h399; in_valid = 1'b1; reset_n = 1'b0;
    #1 chk("async_rst_readdata", readdata, 32'h0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    rd(2'd1, rv); chk("post_rst_status", rv, 32'h0001_0000);
    rd(2'd2, rv); chk("post_rst_enable", rv, 32'h0);
    push(32'h400);
    rd(2'd1, rv); chk("disabled_ignored", rv, 32'h0001_0000);
    wr(2'd2, 32'h1);
    push(32'h401);
    rd(2'd0, rv); chk("reenable_word", rv, 32'h401);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/va_readout_ctrl.md
# va_readout_ctrl

Readout controller that buffers result words from the vector-analyzer core and serves them to the HPS over a 4-word Avalon-MM slave. It sits between the analyzer's result strobe and the lightweight HPS bridge. It sequences words through a FIFO and pops one word per data read. It also exposes fill level, overflow status and capture control, so software drains results without racing the analyzer.

## Interface
Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (16 words); legal range 2..10
- LVL_W, DEPTH_LOG2+1, fill-level width (derived, not overridden)

Ports:
- clk  in  1  system clock, single domain
- reset_n  in  1  asynchronous active-low reset
- address  in  2  Avalon word address
- read  in  1  Avalon read strobe
- write  in  1  Avalon write strobe
- writedata  in  32  Avalon write data
- readdata  out  32  registered Avalon read data
- in_data  in  32  analyzer result word
- in_valid  in  1  one-cycle strobe qualifying in_data; no backpressure
- irq  out  1  level interrupt: enable & level ≥ half depth, or overflow set

## Operation
- Register map:
  - addr 0 DATA (R): FIFO head word; the read pops one word. Returns 0 with no pop when empty.
  - addr 1 STATUS (R): [LVL_W-1:0] level, [16] empty, [17] full, [18] overflow (sticky), [19] enable; other bits 0.
  - addr 2 CONTROL:
    - W: bit0 enable; bit1 flush (self-clearing); bit2 clear overflow.
    - R: {31'b0, enable}.
  - addr 3 DROPCNT (R): see Configuration.
- Writes to addr 0, 1 and 3 are ignored. Reads have no side effect except the DATA pop.
- Push: in_valid & enable & (not full, or pop in the same cycle).
- Drop: in_valid & enable & full & no pop. A drop sets overflow.
- in_valid with enable=0 is ignored silently: no push, no drop.
- Simultaneous events:
  - Push+pop on non-empty FIFO: level unchanged, both take effect.
  - Push+pop on empty FIFO: pop ignored (readdata 0), push accepted, level becomes 1.
  - Flush+push: flush wins. Pointers and level go to 0, the word is discarded and not counted as a drop.
  - Clear-overflow+drop in the same cycle: set wins.
  - Flush does not clear overflow or DROPCNT.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. Level saturates logic-free: it never exceeds 2^DEPTH_LOG2 by construction.
- Storage is inferred RAM or registers. Head data must be available combinationally for the registered readdata (show-ahead).

## Timing
- Reset values: readdata=0, irq=0, enable=0, overflow=0, level=0, pointers=0, DROPCNT=0.
- Read latency 1: readdata is updated at the edge after read is sampled and holds until the next read. No waitrequest.
- When read is low, readdata holds its value.
- Pop occurs at the same edge that loads readdata.
- No write-to-read bypass: a word pushed at edge N is visible to a DATA read sampled at edge N+1 or later.
- STATUS sampled at edge N reflects state before edge N's updates.
- CONTROL write at edge N: enable takes effect for in_valid sampled at edge N+1. Flush completes at edge N.
- irq is registered and lags the level/overflow change by 1 cycle.
- Reset asserted mid-operation: all state clears immediately and asynchronously, and FIFO contents are discarded. Storage need not be cleared, but is unreadable until rewritten.

## Configuration
- VA_READOUT_DROPCNT_EN defined:
  - Addr 3 returns a 16-bit drop counter in [15:0]. It increments per dropped word and saturates at 0xFFFF.
  - It is cleared by the CONTROL bit2 write, unless a drop occurs in the same cycle, in which case the counter becomes 1.
- VA_READOUT_DROPCNT_EN undefined: addr 3 reads 0 and no counter logic is present.

## Test plan
- Reset, then read addr 1 → 0x00010000 (empty). Read addr 0 → 0. irq=0.
- Write addr 2 = 1, push 0xA5A50001..0xA5A50003, read addr 0 three times → words in order with one-cycle latency. STATUS level 3→0. Fourth read → 0.
- DEPTH_LOG2=4, enable, push 18 words without reads → STATUS = 0x000E0010 (enable, overflow, full, level 16). DROPCNT=2 if the macro is defined, else 0. irq=1.
- Full FIFO, in_valid coincident with DATA read → read returns oldest word, new word accepted, level stays 16, no drop.
- Level 5, write addr 2 = 0x3 coincident with in_valid → level 0, empty set, overflow unchanged, enable stays 1.
- Level 7, reset_n low for 1 cycle mid-burst → readdata=0, STATUS=0x00010000, enable=0, in_valid then ignored until re-enabled.
